// File: rtl/pc_gen.sv
// pc_gen: RV32I fetch-stage program-counter generator.
// Next PC comes from sequential (+4), PC-relative (branch/JAL), register-relative (JALR)
// or the saved EPC (mret). A misaligned target redirects fetch to TRAP_VECTOR,
// captures the faulting PC in epc, and inserts one bubble cycle.
// Optional feature macro: PC_GEN_PERF_EN (adds redirect_cnt / stall_cnt outputs).
module pc_gen #(
    parameter int unsigned                DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]      RESET_VECTOR = DATA_WIDTH'('h0000_0000),
    parameter logic [DATA_WIDTH-1:0]      TRAP_VECTOR  = DATA_WIDTH'('h0000_0100)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [1:0]            pc_src,
    input  logic [DATA_WIDTH-1:0] imm_op,
    input  logic [DATA_WIDTH-1:0] rs1_val,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic                  pc_valid,
    output logic                  trap,
`ifdef PC_GEN_PERF_EN
    output logic [31:0]           redirect_cnt,
    output logic [31:0]           stall_cnt,
`endif
    output logic [DATA_WIDTH-1:0] epc
);

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_VECTOR = 2'd2;

    localparam logic [1:0] SRC_SEQ  = 2'b00;
    localparam logic [1:0] SRC_REL  = 2'b01;
    localparam logic [1:0] SRC_JALR = 2'b10;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_epc;

    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_jalr_sum;
    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_misaligned;
    logic                  w_advance;
    logic                  w_trap;

    assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);
    assign w_jalr_sum = rs1_val + imm_op;

    // Target selection for the next fetch address (wrap-around arithmetic)
    always_comb begin
        w_target = w_pc_plus4;
        case (pc_src)
            SRC_SEQ:  w_target = w_pc_plus4;
            SRC_REL:  w_target = r_pc + imm_op;
            SRC_JALR: w_target = {w_jalr_sum[DATA_WIDTH-1:1], 1'b0};
            default:  w_target = r_epc;
        endcase
    end

    assign w_misaligned = (w_target[1:0] != 2'b00);
    // Selection only takes effect in RUN when the hazard unit is not holding us
    assign w_advance    = (r_state == ST_RUN) && !stall;
    assign w_trap       = w_advance && w_misaligned;

    // PC, EPC and fetch-state update; reset overrides stall and any in-flight trap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_VECTOR;
            r_epc   <= '0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!stall) begin
                        if (w_misaligned) begin
                            r_pc    <= TRAP_VECTOR;
                            r_epc   <= r_pc;
                            r_state <= ST_VECTOR;
                        end else begin
                            r_pc    <= w_target;
                        end
                    end
                end
                ST_VECTOR: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_BOOT;
                    r_pc    <= RESET_VECTOR;
                end
            endcase
        end
    end

`ifdef PC_GEN_PERF_EN
    logic [31:0] r_redirect_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating performance counters for taken redirects and stalled RUN cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_advance && (pc_src != SRC_SEQ) && !w_misaligned && (r_redirect_cnt != '1))
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            if ((r_state == ST_RUN) && stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign redirect_cnt = r_redirect_cnt;
    assign stall_cnt    = r_stall_cnt;
`endif

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;
    assign pc_valid = (r_state == ST_RUN);
    assign trap     = w_trap;
    assign epc      = r_epc;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen (default 32-bit build).
// Inputs change 1ns after the rising edge; outputs are checked there or just before
// the next edge for the combinational trap pulse.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [1:0]  pc_src;
    logic [31:0] imm_op;
    logic [31:0] rs1_val;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_valid;
    logic        trap;
    logic [31:0] epc;
`ifdef PC_GEN_PERF_EN
    logic [31:0] redirect_cnt;
    logic [31:0] stall_cnt;
`endif

    int unsigned total;
    int unsigned bad;

    pc_gen #(
        .DATA_WIDTH   (32),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .pc_src   (pc_src),
        .imm_op   (imm_op),
        .rs1_val  (rs1_val),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .pc_valid (pc_valid),
        .trap     (trap),
`ifdef PC_GEN_PERF_EN
        .redirect_cnt (redirect_cnt),
        .stall_cnt    (stall_cnt),
`endif
        .epc      (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        stall   = 1'b0;
        pc_src  = 2'b00;
        imm_op  = '0;
        rs1_val = '0;

        // 1: reset for three cycles, then BOOT bubble, then sequential fetch
        tick(); tick(); tick();
        chk("rst_pc",    pc,              32'h0);
        chk("rst_valid", {31'b0,pc_valid}, 32'h0);
        chk("rst_trap",  {31'b0,trap},     32'h0);
        chk("rst_epc",   epc,             32'h0);
        rst = 1'b0;
        tick();
        chk("boot_pc",    pc,               32'h0);
        chk("boot_valid", {31'b0,pc_valid}, 32'h1);
        tick(); chk("seq_4", pc, 32'h4);
        tick(); chk("seq_8", pc, 32'h8);
        tick(); chk("seq_c", pc, 32'hC);
        chk("plus4_c", pc_plus4, 32'h10);
        tick(); chk("seq_10", pc, 32'h10);

        // 2: relative branch backwards, then wrap of the sequential add
        pc_src = 2'b01; imm_op = 32'hFFFF_FFF8;
        tick(); chk("br_neg8", pc, 32'h8);
        imm_op = 32'hFFFF_FFF4;
        tick(); chk("br_top", pc, 32'hFFFF_FFFC);
        chk("plus4_wrap", pc_plus4, 32'h0);
        pc_src = 2'b00;
        tick(); chk("seq_wrap", pc, 32'h0);
        tick(); chk("seq_after_wrap", pc, 32'h4);

        // 3: JALR to 0x202 is misaligned -> trap to vector with bubble
        pc_src = 2'b10; rs1_val = 32'h203; imm_op = 32'h0;
        #1; chk("jalr_trap_pulse", {31'b0,trap}, 32'h1);
        tick();
        chk("vec_pc",    pc,               32'h100);
        chk("vec_epc",   epc,              32'h4);
        chk("vec_valid", {31'b0,pc_valid}, 32'h0);
        pc_src = 2'b01; imm_op = 32'h2;
        #1; chk("vec_trap_low", {31'b0,trap}, 32'h0);
        tick();
        chk("vec_exit_pc",    pc,               32'h100);
        chk("vec_exit_valid", {31'b0,pc_valid}, 32'h1);

        // 4: mret back to epc, then stall holds PC and suppresses trap
        pc_src = 2'b11;
        tick(); chk("mret_pc", pc, 32'h4);
        stall = 1'b1; pc_src = 2'b01; imm_op = 32'h2;
        for (int i = 0; i < 3; i++) begin
            #1; chk("stall_trap", {31'b0,trap}, 32'h0);
            tick();
            chk("stall_pc",    pc,               32'h4);
            chk("stall_valid", {31'b0,pc_valid}, 32'h1);
        end
        stall = 1'b0; pc_src = 2'b00;
        tick(); chk("unstall_pc", pc, 32'h8);

        // 5: reset asserted while in VECTOR, stall must not block reset or BOOT exit
        pc_src = 2'b01; imm_op = 32'h2;
        #1; chk("br_trap_pulse", {31'b0,trap}, 32'h1);
        tick();
        chk("vec2_pc",  pc,  32'h100);
        chk("vec2_epc", epc, 32'h8);
        rst = 1'b1; stall = 1'b1;
        tick();
        chk("midtrap_rst_pc",    pc,               32'h0);
        chk("midtrap_rst_epc",   epc,              32'h0);
        chk("midtrap_rst_trap",  {31'b0,trap},     32'h0);
        chk("midtrap_rst_valid", {31'b0,pc_valid}, 32'h0);
        rst = 1'b0;
        tick();
        chk("boot_stall_valid", {31'b0,pc_valid}, 32'h1);
        chk("boot_stall_pc",    pc,               32'h0);

        // 6: two branches and three stalls for the performance counters
        rst = 1'b1; stall = 1'b0; pc_src = 2'b00;
        tick();
        rst = 1'b0;
        tick();
        pc_src = 2'b01; imm_op = 32'h4;
        tick(); chk("perf_br1", pc, 32'h4);
        tick(); chk("perf_br2", pc, 32'h8);
        pc_src = 2'b00; stall = 1'b1;
        tick(); tick(); tick();
        chk("perf_stall_pc", pc, 32'h8);
        stall = 1'b0;
`ifdef PC_GEN_PERF_EN
        chk("redirect_cnt", redirect_cnt, 32'd2);
        chk("stall_cnt",    stall_cnt,    32'd3);
`endif
        rst = 1'b1;
        tick();
`ifdef PC_GEN_PERF_EN
        chk("redirect_clr", redirect_cnt, 32'd0);
        chk("stall_clr",    stall_cnt,    32'd0);
`endif
        chk("final_rst_pc", pc, 32'h0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
